// File: rtl/instr_encoder_loader.sv
// Encodes RV32IM instruction words from aluSelect codes and streams them to instruction memory.
// One registered stage (1-cycle latency); a held word stalls new requests until memory accepts it.
module instr_encoder_loader #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                COUNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         in_code,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [31:0]        in_imm,
   input  logic               clear,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_addr,
   output logic [31:0]        out_instr,
   output logic [COUNT_W-1:0] word_count,
   output logic               err_illegal
);

   typedef enum logic [2:0] {
      FMT_NOP, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
   } fmt_e;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
   localparam logic [6:0] F7_MUL   = 7'b0000001;

   logic [6:0]         w_op;
   logic [2:0]         w_f3;
   logic [6:0]         w_f7;
   fmt_e               w_fmt;
   logic               w_legal;
   logic [31:0]        w_enc;
   logic               w_fire;
   logic               w_accept;

   logic               r_vld;
   logic [31:0]        r_instr;
   logic [ADDR_W-1:0]  r_addr;
   logic [COUNT_W-1:0] r_cnt;
   logic               r_err;

   always_comb begin
      w_op    = 7'h00;
      w_f3    = 3'd0;
      w_f7    = 7'h00;
      w_fmt   = FMT_NOP;
      w_legal = 1'b1;
      case (in_code)
         6'd0:  w_fmt = FMT_NOP;
         6'd1:  begin w_op = OP_LUI;   w_fmt = FMT_U; end
         6'd2:  begin w_op = OP_AUIPC; w_fmt = FMT_U; end
         6'd3:  begin w_op = OP_JAL;   w_fmt = FMT_J; end
         6'd4:  begin w_op = OP_JALR;  w_fmt = FMT_I; end
         6'd5:  begin w_op = OP_BR;    w_fmt = FMT_B; w_f3 = 3'd0; end
         6'd6:  begin w_op = OP_BR;    w_fmt = FMT_B; w_f3 = 3'd1; end
         6'd7:  begin w_op = OP_BR;    w_fmt = FMT_B; w_f3 = 3'd4; end
         6'd8:  begin w_op = OP_BR;    w_fmt = FMT_B; w_f3 = 3'd5; end
         6'd9:  begin w_op = OP_BR;    w_fmt = FMT_B; w_f3 = 3'd6; end
         6'd10: begin w_op = OP_BR;    w_fmt = FMT_B; w_f3 = 3'd7; end
         6'd11: begin w_op = OP_LD;    w_fmt = FMT_I; w_f3 = 3'd0; end
         6'd12: begin w_op = OP_LD;    w_fmt = FMT_I; w_f3 = 3'd1; end
         6'd13: begin w_op = OP_LD;    w_fmt = FMT_I; w_f3 = 3'd2; end
         6'd14: begin w_op = OP_LD;    w_fmt = FMT_I; w_f3 = 3'd4; end
         6'd15: begin w_op = OP_LD;    w_fmt = FMT_I; w_f3 = 3'd5; end
         6'd16: begin w_op = OP_ST;    w_fmt = FMT_S; w_f3 = 3'd0; end
         6'd17: begin w_op = OP_ST;    w_fmt = FMT_S; w_f3 = 3'd1; end
         6'd18: begin w_op = OP_ST;    w_fmt = FMT_S; w_f3 = 3'd2; end
         6'd19: begin w_op = OP_IMM;   w_fmt = FMT_I; w_f3 = 3'd0; end
         6'd20: begin w_op = OP_IMM;   w_fmt = FMT_I; w_f3 = 3'd2; end
         6'd21: begin w_op = OP_IMM;   w_fmt = FMT_I; w_f3 = 3'd3; end
         6'd22: begin w_op = OP_IMM;   w_fmt = FMT_I; w_f3 = 3'd4; end
         6'd23: begin w_op = OP_IMM;   w_fmt = FMT_I; w_f3 = 3'd6; end
         6'd24: begin w_op = OP_IMM;   w_fmt = FMT_I; w_f3 = 3'd7; end
         6'd25: begin w_op = OP_IMM;   w_fmt = FMT_SH; w_f3 = 3'd1; end
         6'd26: begin w_op = OP_IMM;   w_fmt = FMT_SH; w_f3 = 3'd5; end
         6'd27: begin w_op = OP_IMM;   w_fmt = FMT_SH; w_f3 = 3'd5; w_f7 = F7_ALT; end
         6'd36: begin w_op = OP_REG;   w_fmt = FMT_R; w_f3 = 3'd0; w_f7 = F7_ALT; end
         6'd37: begin w_op = OP_REG;   w_fmt = FMT_R; w_f3 = 3'd5; w_f7 = F7_ALT; end
         default: begin
            // Base and M-extension register ops each run through f3 0..7 in code order.
            if (in_code >= 6'd28 && in_code <= 6'd35) begin
               w_op  = OP_REG;
               w_fmt = FMT_R;
               w_f3  = in_code[2:0] - 3'd4;
            end else if (in_code >= 6'd38 && in_code <= 6'd45) begin
               w_op  = OP_REG;
               w_fmt = FMT_R;
               w_f3  = in_code[2:0] - 3'd6;
               w_f7  = F7_MUL;
            end else begin
               w_legal = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      w_enc = 32'h00000013;
      case (w_fmt)
         FMT_R:  w_enc = {w_f7, in_rs2, in_rs1, w_f3, in_rd, w_op};
         FMT_I:  w_enc = {in_imm[11:0], in_rs1, w_f3, in_rd, w_op};
         FMT_SH: w_enc = {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, w_op};
         FMT_S:  w_enc = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], w_op};
         FMT_B:  w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                          in_imm[4:1], in_imm[11], w_op};
         FMT_U:  w_enc = {in_imm[31:12], in_rd, w_op};
         FMT_J:  w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_op};
         default: w_enc = 32'h00000013;
      endcase
   end

   assign in_ready = !clear && (!r_vld || out_ready);
   assign w_fire   = r_vld && out_ready;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld   <= 1'b0;
         r_instr <= 32'h0;
         r_addr  <= BASE_ADDR;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else if (clear) begin
         r_vld  <= 1'b0;
         r_addr <= BASE_ADDR;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         // r_addr always names the slot for the held word, so it moves only when a word leaves.
         if (w_fire) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_cnt != '1)
               r_cnt <= r_cnt + COUNT_W'(1);
         end
         if (w_accept && w_legal) begin
            r_vld   <= 1'b1;
            r_instr <= w_enc;
         end else if (w_fire) begin
            r_vld <= 1'b0;
         end
         if (w_accept && !w_legal)
            r_err <= 1'b1;
      end
   end

   assign out_valid   = r_vld;
   assign out_instr   = r_instr;
   assign out_addr    = r_addr;
   assign word_count  = r_cnt;
   assign err_illegal = r_err;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the decode-stage control unit. Takes an operation code, using the same 6-bit aluSelect numbering the decoder emits, plus register fields and an immediate, and encodes a 32-bit RV32IM instruction word. Encoded words stream to instruction memory over a valid/ready write port with an auto-incrementing word address. Used for bench program loading and for round-trip checking against the decoder.

Parameters:
ADDR_W, 32, width of out_addr
BASE_ADDR, 0, first write address; also the address after clear
COUNT_W, 16, width of word_count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_code  in  6  operation code, aluSelect numbering
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  immediate, full byte-offset/value form
clear  in  1  sync: drop held word, address to BASE_ADDR, zero counters/error
out_valid  out  1  write valid
out_ready  in  1  memory accepts the write
out_addr  out  ADDR_W  byte address of out_instr
out_instr  out  32  encoded instruction
word_count  out  COUNT_W  number of words written
err_illegal  out  1  sticky: an illegal code was accepted

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_instr=0, out_addr=BASE_ADDR, word_count=0, err_illegal=0. Reset mid-transfer discards the held word.
- One output register. in_ready = !clear && (!out_valid || out_ready). Latency is 1 cycle: an accepted request appears on out_instr/out_valid the next cycle.
- While out_valid && !out_ready, out_instr and out_addr hold stable.
- Write fire (out_valid && out_ready): out_addr += 4, wrapping mod 2^ADDR_W; word_count += 1, saturating at all-ones.
- Simultaneous fire and accept: the new word loads, and out_addr advances exactly once for the fired word.
- clear has priority over everything: out_valid=0, out_addr=BASE_ADDR, word_count=0, err_illegal=0; no accept that cycle.
- Code map, listed as code: mnemonic, opcode, funct3, funct7:
  - 0: NOP, emits 0x00000013.
  - 1: LUI, 0110111. 2: AUIPC, 0010111.
  - 3: JAL, 1101111. 4: JALR, 1100111, f3 0.
  - 5-10: BEQ, BNE, BLT, BGE, BLTU, BGEU; opcode 1100011; f3 0, 1, 4, 5, 6, 7.
  - 11-15: LB, LH, LW, LBU, LHU; opcode 0000011; f3 0, 1, 2, 4, 5.
  - 16-18: SB, SH, SW; opcode 0100011; f3 0, 1, 2.
  - 19-27: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; opcode 0010011; f3 0, 2, 3, 4, 6, 7, 1, 5, 5. SRAI uses f7 0100000; SLLI and SRLI use f7 0.
  - 28-35: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND; opcode 0110011; f3 0-7; f7 0.
  - 36: SUB, f3 0, f7 0100000. 37: SRA, f3 5, f7 0100000.
  - 38-45: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; opcode 0110011; f3 0-7; f7 0000001.
- Immediate formats:
  - I: in_imm[11:0].
  - Shift-immediate: f7 followed by in_imm[4:0].
  - S: in_imm[11:5] and in_imm[4:0].
  - B: in_imm[12|10:5] and [4:1|11].
  - U: in_imm[31:12].
  - J: in_imm[20|10:1|11|19:12].
  - Bits outside each field are ignored; no range checking. in_imm[0] is ignored for B and J.
- Unused register fields encode as their input values where the format has them. rs2 is placed only in R, S and B formats.
- Codes 46-63 are illegal: the request is accepted, no word is emitted, err_illegal sets, and the address is unchanged.

Test Plan:
- After reset, code 19 (ADDI), rd=1, rs1=0, imm=5 -> next cycle out_instr=0x00500093, out_addr=0; fire -> word_count=1.
- Back-to-back codes 28 (ADD rd=3, rs1=1, rs2=2), 18 (SW rs1=1, rs2=2, imm=8), 38 (MUL rd=5, rs1=6, rs2=7), out_ready=1 -> 0x002081B3 @0, 0x0020A423 @4, 0x027302B3 @8; one word per cycle.
- Code 3 (JAL) rd=1, imm=8, then code 36 (SUB) rd=0, rs1=0, rs2=0 -> 0x008000EF, then 0x40000033; code 0 -> 0x00000013.
- out_ready=0 for 3 cycles with a word held -> out_instr and out_addr stable, in_ready=0; release -> exactly one fire, address +4.
- Code 50 accepted -> out_valid stays 0, err_illegal=1 and sticky, out_addr unchanged; clear -> err_illegal=0, out_addr=BASE_ADDR, word_count=0.
- rst_n low while a word is held with out_ready=0 -> out_valid drops immediately (asynchronously); after release, first word goes to BASE_ADDR.
